// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state, owner and arbitration-mode constants for the SRAM arbiter.
package sram_arb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;
    localparam int ARB_RR = 0;
    localparam int ARB_FIXED = 1;
endpackage

// File: rtl/sram_arb_if.sv
// sram_arb_if: request/acknowledge port between a bus requester and the SRAM arbiter.
interface sram_arb_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    modport master (output req, output we, output addr, output wdata, input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: two-way winner select; sel is the winning owner when grant is high.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic grant,
    output logic sel
);
    always_comb begin
        grant = cpu_req | dma_req;
        sel   = (cpu_req && dma_req) ? ((ARB_MODE == ARB_FIXED) ? OWN_CPU : ~last_grant) : dma_req;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares an async SRAM between CPU and DMA ports with timed, registered strobes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int ARB_MODE    = ARB_RR
) (
    input  logic              clk,
    input  logic              n_reset,
    sram_arb_if.slave         cpu,
    sram_arb_if.slave         dma,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              n_sram_ce,
    output logic              n_sram_oe,
    output logic              n_sram_we,
    output logic              owner,
    output logic              busy
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("WAIT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              busy_q, busy_d;
    logic              grant, sel;

    sram_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
        .cpu_req    (cpu.req),
        .dma_req    (dma.req),
        .last_grant (last_q),
        .grant      (grant),
        .sel        (sel)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d = SETUP;
                owner_d = sel;
                last_d  = sel;
                we_d    = sel ? dma.we : cpu.we;
                addr_d  = sel ? dma.addr : cpu.addr;
                dq_o_d  = we_d ? (sel ? dma.wdata : cpu.wdata) : dq_o_q;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CW'(WAIT_CYCLES - 1);
            end
            ACCESS: if (cnt_q == '0) begin
                state_d     = HOLD;
                cpu_rdata_d = (!we_q && owner_q == OWN_CPU) ? sram_dq_i : cpu_rdata_q;
                dma_rdata_d = (!we_q && owner_q == OWN_DMA) ? sram_dq_i : dma_rdata_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Strobes are decoded from the next state so every pin comes straight from a flop.
        ce_n_d    = state_d == IDLE;
        oe_n_d    = !(state_d == ACCESS && !we_d);
        we_n_d    = !(state_d == ACCESS && we_d);
        dq_oe_d   = we_d && state_d != IDLE;
        cpu_ack_d = state_d == HOLD && owner_d == OWN_CPU;
        dma_ack_d = state_d == HOLD && owner_d == OWN_DMA;
        busy_d    = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DMA;
            addr_q      <= '0;
            dq_o_q      <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign n_sram_ce  = ce_n_q;
    assign n_sram_oe  = oe_n_q;
    assign n_sram_we  = we_n_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign cpu.ack    = cpu_ack_q;
    assign dma.rdata  = dma_rdata_q;
    assign dma.ack    = dma_ack_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors on a round-robin instance plus a fixed-priority instance.
module tb_sram_arbiter;
    localparam int AW = 21;
    localparam int DW = 8;
    localparam int W  = 2;
    localparam int LAT = W + 2;
    localparam int PERIOD = W + 3;

    typedef struct {
        logic          dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_rr ();
    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) dma_rr ();
    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_fx ();
    sram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) dma_fx ();

    logic [AW-1:0] addr_rr, addr_fx;
    logic [DW-1:0] dq_o_rr, dq_o_fx, dq_i_rr;
    logic [DW-1:0] dq_i_fx = '0;
    logic dq_oe_rr, ce_rr, oe_rr, we_rr, owner_rr, busy_rr;
    logic dq_oe_fx, ce_fx, oe_fx, we_fx, owner_fx, busy_fx;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .ARB_MODE(0)) u_rr (
        .clk(clk), .n_reset(n_reset), .cpu(cpu_rr), .dma(dma_rr),
        .sram_addr(addr_rr), .sram_dq_o(dq_o_rr), .sram_dq_oe(dq_oe_rr), .sram_dq_i(dq_i_rr),
        .n_sram_ce(ce_rr), .n_sram_oe(oe_rr), .n_sram_we(we_rr), .owner(owner_rr), .busy(busy_rr)
    );

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .ARB_MODE(1)) u_fx (
        .clk(clk), .n_reset(n_reset), .cpu(cpu_fx), .dma(dma_fx),
        .sram_addr(addr_fx), .sram_dq_o(dq_o_fx), .sram_dq_oe(dq_oe_fx), .sram_dq_i(dq_i_fx),
        .n_sram_ce(ce_fx), .n_sram_oe(oe_fx), .n_sram_we(we_fx), .owner(owner_fx), .busy(busy_fx)
    );

    logic [DW-1:0] mem [2**AW];
    assign dq_i_rr = mem[addr_rr];
    always @(posedge clk) begin
        if (preload) mem[21'h1A2B3] <= 8'h5C;
        else if (!we_rr && !ce_rr) mem[addr_rr] <= dq_o_rr;
    end

    int ce_tot = 0, oe_tot = 0, we_tot = 0, dqoe_tot = 0, cack_tot = 0, dack_tot = 0;
    int viol_ov = 0, viol_wc = 0;
    always @(negedge clk) begin
        if (!ce_rr) ce_tot++;
        if (!oe_rr) oe_tot++;
        if (!we_rr) we_tot++;
        if (dq_oe_rr) dqoe_tot++;
        if (cpu_rr.ack) cack_tot++;
        if (dma_rr.ack) dack_tot++;
        if ((!oe_rr && dq_oe_rr) || (!oe_fx && dq_oe_fx)) viol_ov++;
        if ((!we_rr && ce_rr) || (!we_fx && ce_fx)) viol_wc++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vec_t v;
        int ce0, oe0, we0, dqoe0, cack0, dack0, lat, n;
        logic got;
        logic ports[8];
        int when[8];
        logic owns[8];
        vecs[0] = '{1'b0, 1'b0, 21'h1A2B3, 8'h00, 8'h5C};
        vecs[1] = '{1'b1, 1'b1, 21'h00010, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 21'h1FFFFF, 8'h3C, 8'h5C};
        vecs[3] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 21'h00010, 8'h00, 8'hA5};
        vecs[5] = '{1'b0, 1'b1, 21'h1A2B3, 8'h77, 8'h3C};
        vecs[6] = '{1'b0, 1'b0, 21'h1A2B3, 8'h00, 8'h77};
        {cpu_rr.req, cpu_rr.we, cpu_rr.addr, cpu_rr.wdata} = '0;
        {dma_rr.req, dma_rr.we, dma_rr.addr, dma_rr.wdata} = '0;
        {cpu_fx.req, cpu_fx.we, cpu_fx.addr, cpu_fx.wdata} = '0;
        {dma_fx.req, dma_fx.we, dma_fx.addr, dma_fx.wdata} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", ce_rr, 1);
        chk("rst_oe", oe_rr, 1);
        chk("rst_we", we_rr, 1);
        chk("rst_dq_oe", dq_oe_rr, 0);
        chk("rst_addr", addr_rr, 0);
        chk("rst_dq_o", dq_o_rr, 0);
        chk("rst_rdata", {cpu_rr.rdata, dma_rr.rdata}, 0);
        chk("rst_acks", {cpu_rr.ack, dma_rr.ack}, 0);
        chk("rst_busy_owner", {busy_rr, owner_rr}, 0);
        n_reset = 1'b1;
        preload = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            ce0 = ce_tot; oe0 = oe_tot; we0 = we_tot; dqoe0 = dqoe_tot; cack0 = cack_tot; dack0 = dack_tot;
            if (v.dma) {dma_rr.we, dma_rr.addr, dma_rr.wdata, dma_rr.req} = {v.we, v.addr, v.wdata, 1'b1};
            else {cpu_rr.we, cpu_rr.addr, cpu_rr.wdata, cpu_rr.req} = {v.we, v.addr, v.wdata, 1'b1};
            lat = 0;
            got = 1'b0;
            for (int c = 1; c <= 20 && !got; c++) begin
                @(posedge clk);
                #1;
                if (v.dma ? dma_rr.ack : cpu_rr.ack) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            chk("latency", lat, LAT);
            chk("owner", owner_rr, v.dma);
            chk("busy_hold", busy_rr, 1);
            chk("addr", addr_rr, v.addr);
            if (v.we) chk("dq_o", dq_o_rr, v.wdata);
            cpu_rr.req = 1'b0;
            dma_rr.req = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("ce_low", ce_tot - ce0, 4);
            chk("oe_low", oe_tot - oe0, v.we ? 0 : W);
            chk("we_low", we_tot - we0, v.we ? W : 0);
            chk("dq_oe_hi", dqoe_tot - dqoe0, v.we ? 4 : 0);
            chk("own_ack", v.dma ? dack_tot - dack0 : cack_tot - cack0, 1);
            chk("other_ack", v.dma ? cack_tot - cack0 : dack_tot - dack0, 0);
            chk("rdata", v.dma ? dma_rr.rdata : cpu_rr.rdata, v.exp_rdata);
            if (v.we) chk("mem", mem[v.addr], v.wdata);
            chk("busy_idle", busy_rr, 0);
        end

        // reset while a DMA write is strobing
        dack0 = dack_tot;
        cack0 = cack_tot;
        {dma_rr.we, dma_rr.addr, dma_rr.wdata, dma_rr.req} = {1'b1, 21'h00020, 8'h11, 1'b1};
        repeat (2) @(posedge clk);
        #1;
        chk("mid_we_low", we_rr, 0);
        #2;
        n_reset = 1'b0;
        #1;
        chk("mid_rst_we", we_rr, 1);
        chk("mid_rst_ce", ce_rr, 1);
        chk("mid_rst_acks", {cpu_rr.ack, dma_rr.ack}, 0);
        chk("mid_rst_dq_oe", dq_oe_rr, 0);
        chk("mid_rst_busy", busy_rr, 0);
        dma_rr.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_ack", (dack_tot - dack0) + (cack_tot - cack0), 0);

        // round-robin with both ports held
        {cpu_rr.we, cpu_rr.addr, cpu_rr.req} = {1'b0, 21'h1A2B3, 1'b1};
        {dma_rr.we, dma_rr.addr, dma_rr.req} = {1'b0, 21'h00010, 1'b1};
        n = 0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            @(posedge clk);
            #1;
            if (cpu_rr.ack || dma_rr.ack) begin
                ports[n] = dma_rr.ack;
                owns[n] = owner_rr;
                when[n] = c;
                n++;
            end
        end
        cpu_rr.req = 1'b0;
        dma_rr.req = 1'b0;
        chk("rr_count", n, 4);
        for (int k = 0; k < n; k++) begin
            chk("rr_port", ports[k], k % 2);
            chk("rr_owner", owns[k], k % 2);
            if (k == 0) chk("rr_first_lat", when[k], LAT);
            else chk("rr_gap", when[k] - when[k-1], PERIOD);
        end
        repeat (3) @(posedge clk);
        #1;

        // fixed priority: CPU starves DMA until it lets go
        {cpu_fx.we, cpu_fx.addr, cpu_fx.req} = {1'b0, 21'h00100, 1'b1};
        {dma_fx.we, dma_fx.addr, dma_fx.req} = {1'b0, 21'h00200, 1'b1};
        n = 0;
        for (int c = 1; c <= 40 && n < 3; c++) begin
            @(posedge clk);
            #1;
            if (cpu_fx.ack || dma_fx.ack) begin
                ports[n] = dma_fx.ack;
                n++;
            end
        end
        cpu_fx.req = 1'b0;
        chk("fx_count", n, 3);
        for (int k = 0; k < n; k++) chk("fx_cpu_wins", ports[k], 0);
        got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (cpu_fx.ack || dma_fx.ack) begin
                got = 1'b1;
                ports[0] = dma_fx.ack;
                owns[0] = owner_fx;
            end
        end
        dma_fx.req = 1'b0;
        chk("fx_dma_got_ack", got, 1);
        chk("fx_dma_next", ports[0], 1);
        chk("fx_dma_owner", owns[0], 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_oe_dq_overlap", viol_ov, 0);
        chk("no_we_without_ce", viol_wc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
